defuzz_nt: RTL and testbench
============================

DEFUZZ_NT -- requirements
Module: defuzz_nt

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named CLK and RESET.
REQ-002 Parameter Y_C0..Y_C8, defaults 0,32,64,96,128,159,191,223,255: 8-bit consequent centroid of rule i.
REQ-003 Parameter Y_ZERO, default 8'd0: Saida value when total firing is zero.
REQ-004 CLK  input  1: rising-edge clock.
REQ-005 RESET  input  1: synchronous reset, active high.
REQ-006 Start  input  1: request a defuzzification; sampled only in IDLE.
REQ-007 Firing_UP  input  72: nine 8-bit upper firing strengths; rule i occupies bits [8i+7:8i], with i = 3*m + n, where m is the x1 set index and n is the x2 set index.
REQ-008 Firing_LOW  input  72: nine 8-bit lower firing strengths, same packing as Firing_UP.
REQ-009 Saida  output  8: crisp output, held until the next completion.
REQ-010 Ocupado  output  1: high in every state except IDLE.
REQ-011 Pronto  output  1: one-cycle pulse when Saida is updated.
REQ-012 Erro  output  1: set when the last result came from a zero denominator; updated together with Saida.

Function
REQ-013 Type reduction SHALL use the Nie-Tan method: s_i = UP_i + LOW_i (9 bits), N = sum(s_i*Y_Ci) (21 bits), D = sum(s_i) (13 bits), Saida = floor(N/D).
REQ-014 No input SHALL be saturated or clamped.
  - Values above TOPO (100) are used as-is.
  - UP_i < LOW_i is accepted without a flag.
REQ-015 The FSM SHALL have states IDLE, ACC, DIV and DONE.
REQ-016 IDLE -> ACC when Start=1; on that edge Firing_UP and Firing_LOW are registered internally, and N, D and the rule index are cleared.
REQ-017 ACC SHALL take exactly 9 cycles, adding rule index 0..8 (one rule per cycle) into N and D.
  - Leaving ACC with D=0: go to DONE.
  - Leaving ACC with D!=0: go to DIV.
REQ-018 DIV SHALL be a restoring divider that produces one quotient bit per cycle, MSB first, over exactly 8 cycles; then go to DONE.
  - The quotient always fits in 8 bits, because the result is a weighted mean of 8-bit centroids.
REQ-019 DONE SHALL last 1 cycle, then return to IDLE.
  - Pronto=1 during DONE.
  - Saida and Erro are loaded on entry to DONE.
REQ-020 Latency SHALL be fixed:
  - D!=0: Pronto is high in the 18th cycle after the cycle in which Start was sampled.
  - D=0: Pronto is high in the 10th cycle.
REQ-021 On the D=0 path, Saida SHALL be Y_ZERO and Erro=1; otherwise Erro=0.
REQ-022 Start SHALL be ignored while Ocupado=1; it is not queued.
REQ-023 If Start is held high continuously, a new run SHALL begin in the cycle after DONE.
REQ-024 Changes on Firing_UP or Firing_LOW after the Start sample SHALL NOT affect the current result.

Reset
REQ-025 RESET=1 on a rising edge SHALL force: state IDLE, Saida=0, Pronto=0, Ocupado=0, Erro=0, N=0, D=0, index=0.
REQ-026 RESET SHALL take priority over Start and apply in any state, including mid-ACC and mid-DIV.
  - An aborted run never produces a Pronto pulse.

Structure
REQ-027 A shared package SHALL hold:
  - the state encoding;
  - the width constants (8, 9, 13, 21);
  - the rule count (9);
  - TOPO (8'd100);
  - the default centroid table.
REQ-028 The divider SHALL be a sub-module, div_restaurador, with its own start/done handshake and a fixed 8-cycle latency; defuzz_nt instantiates it once.

Verification
REQ-029 All firings 0 -> Pronto at cycle 10, Saida=0, Erro=1.
REQ-030 Rule 4 with UP=100 and LOW=60, all others 0 -> Saida=128, Erro=0, Pronto at cycle 18.
REQ-031 Rule 0 and rule 8 each with UP=LOW=100, others 0 -> N=51000, D=400, Saida=127 (truncated from 127.5).
REQ-032 Start pulsed again at cycles 3 and 12 of a run -> both pulses are ignored and exactly one Pronto occurs; a Start after DONE starts a new run.
REQ-033 RESET asserted at cycle 13 (in DIV) -> all outputs 0 on the next cycle and no Pronto afterwards; a fresh Start then completes normally.
REQ-034 Firing buses changed to all-255 during ACC -> Saida equals the value for the firings captured at Start.

Source files
------------

// File: rtl/defuzz_nt_pkg.sv
// ---------------------------------------------------------------------------
// defuzz_nt_pkg
// Shared definitions for the interval type-2 defuzzifier (Nie-Tan type
// reduction): FSM state encoding, datapath widths, rule count, the nominal
// top of the firing scale and the default consequent centroid table.
// ---------------------------------------------------------------------------
package defuzz_nt_pkg;

  // Datapath widths
  localparam int W_FIRE  = 8;   // one firing strength / one centroid
  localparam int W_SUM   = 9;   // UP_i + LOW_i
  localparam int W_DEN   = 13;  // sum of nine 9-bit sums
  localparam int W_NUM   = 21;  // sum of nine 9x8-bit products
  localparam int N_RULES = 9;

  // Nominal full-scale firing value; inputs above it are still used as-is
  localparam logic [7:0] TOPO = 8'd100;

  // Default centroids, rule 0 in the low byte
  localparam logic [71:0] Y_C_DEF = {8'd255, 8'd223, 8'd191, 8'd159, 8'd128,
                                     8'd96,  8'd64,  8'd32,  8'd0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Select the 8-bit field of rule idx from a 72-bit packed bus
  function automatic logic [7:0] rule_byte(input logic [71:0] bus,
                                           input logic [3:0]  idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = bus[7:0];
      4'd1:    b = bus[15:8];
      4'd2:    b = bus[23:16];
      4'd3:    b = bus[31:24];
      4'd4:    b = bus[39:32];
      4'd5:    b = bus[47:40];
      4'd6:    b = bus[55:48];
      4'd7:    b = bus[63:56];
      4'd8:    b = bus[71:64];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/defuzz_nt_div.sv
// ---------------------------------------------------------------------------
// div_restaurador
// Restoring divider, 21-bit dividend / 13-bit divisor -> 8-bit quotient,
// one quotient bit per cycle MSB first, fixed 8-cycle latency.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start        load operands (one-cycle pulse)
//   dividend     21-bit numerator
//   divisor      13-bit denominator (non-zero)
//   done         high during the 8th busy cycle
//   quotient     valid while done is high
// ---------------------------------------------------------------------------
module div_restaurador
  import defuzz_nt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [W_NUM-1:0]  dividend,
  input  logic [W_DEN-1:0]  divisor,
  output logic              done,
  output logic [7:0]        quotient
);

  logic              busy_r;
  logic [2:0]        cnt_r;
  logic [W_NUM-1:0]  rem_r;
  logic [W_NUM-1:0]  dsh_r;    // divisor aligned to the current quotient bit
  logic [6:0]        q_r;      // quotient bits collected so far
  logic [W_NUM:0]    trial_s;
  logic              bit_s;

  // Trial subtraction for the current bit; a non-negative result keeps it
  always_comb begin
    trial_s  = {1'b0, rem_r} - {1'b0, dsh_r};
    bit_s    = ~trial_s[W_NUM];
    quotient = {q_r, bit_s};
    done     = busy_r && (cnt_r == 3'd7);
  end

  // Divider iteration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      cnt_r  <= 3'd0;
      rem_r  <= {W_NUM{1'b0}};
      dsh_r  <= {W_NUM{1'b0}};
      q_r    <= 7'd0;
    end else if (start) begin
      busy_r <= 1'b1;
      cnt_r  <= 3'd0;
      rem_r  <= dividend;
      dsh_r  <= {1'b0, divisor, 7'd0};
      q_r    <= 7'd0;
    end else if (busy_r) begin
      if (bit_s) begin
        rem_r <= trial_s[W_NUM-1:0];
      end else begin
        rem_r <= rem_r;
      end
      q_r    <= quotient[6:0];
      dsh_r  <= {1'b0, dsh_r[W_NUM-1:1]};
      cnt_r  <= cnt_r + 3'd1;
      busy_r <= (cnt_r != 3'd7);
    end else begin
      busy_r <= 1'b0;
      cnt_r  <= cnt_r;
      rem_r  <= rem_r;
      dsh_r  <= dsh_r;
      q_r    <= q_r;
    end
  end

endmodule

// File: rtl/defuzz_nt.sv
// ---------------------------------------------------------------------------
// defuzz_nt
// Nie-Tan defuzzifier for a 3x3 interval type-2 rule base. On Start the
// firing buses are captured, nine rules are accumulated one per cycle into
// N = sum((UP+LOW)*Y) and D = sum(UP+LOW), then Saida = floor(N/D) via a
// restoring divider. Zero D yields Y_ZERO with Erro set.
// Latency: 18 cycles (D!=0) or 10 cycles (D=0) from Start sample to Pronto.
// Ports:
//   CLK, RESET   clock and synchronous active-high reset
//   Start        run request, sampled only in IDLE
//   Firing_UP    nine 8-bit upper firings, rule i at [8i+7:8i]
//   Firing_LOW   nine 8-bit lower firings, same packing
//   Saida        crisp output, held until the next completion
//   Ocupado      high whenever not IDLE
//   Pronto       one-cycle pulse when Saida/Erro update
//   Erro         last result came from a zero denominator
// ---------------------------------------------------------------------------
module defuzz_nt
  import defuzz_nt_pkg::*;
#(
  parameter logic [7:0] Y_C0   = Y_C_DEF[7:0],
  parameter logic [7:0] Y_C1   = Y_C_DEF[15:8],
  parameter logic [7:0] Y_C2   = Y_C_DEF[23:16],
  parameter logic [7:0] Y_C3   = Y_C_DEF[31:24],
  parameter logic [7:0] Y_C4   = Y_C_DEF[39:32],
  parameter logic [7:0] Y_C5   = Y_C_DEF[47:40],
  parameter logic [7:0] Y_C6   = Y_C_DEF[55:48],
  parameter logic [7:0] Y_C7   = Y_C_DEF[63:56],
  parameter logic [7:0] Y_C8   = Y_C_DEF[71:64],
  parameter logic [7:0] Y_ZERO = 8'd0
)(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Start,
  input  logic [71:0] Firing_UP,
  input  logic [71:0] Firing_LOW,
  output logic [7:0]  Saida,
  output logic        Ocupado,
  output logic        Pronto,
  output logic        Erro
);

  localparam logic [71:0] Y_TAB = {Y_C8, Y_C7, Y_C6, Y_C5, Y_C4,
                                   Y_C3, Y_C2, Y_C1, Y_C0};

  state_t            state_r, state_nx_s;
  logic [71:0]       up_r, low_r;
  logic [W_NUM-1:0]  n_r, n_next_s;
  logic [W_DEN-1:0]  d_r, d_next_s;
  logic [3:0]        idx_r;
  logic [7:0]        saida_r;
  logic              ocupado_r, pronto_r, erro_r;

  logic [W_SUM-1:0]  s_s;
  logic [16:0]       prod_s;
  logic              last_rule_s;
  logic              div_start_s, div_done_s;
  logic [7:0]        div_quo_s;

  assign Saida   = saida_r;
  assign Ocupado = ocupado_r;
  assign Pronto  = pronto_r;
  assign Erro    = erro_r;

  // Contribution of the current rule and the running sums after adding it
  always_comb begin
    s_s         = {1'b0, rule_byte(up_r, idx_r)} + {1'b0, rule_byte(low_r, idx_r)};
    prod_s      = {8'd0, s_s} * {9'd0, rule_byte(Y_TAB, idx_r)};
    n_next_s    = n_r + {4'd0, prod_s};
    d_next_s    = d_r + {4'd0, s_s};
    last_rule_s = (idx_r == 4'd8);
  end

  // Next-state logic; the divider is launched with the final sums as ACC ends
  always_comb begin
    state_nx_s  = state_r;
    div_start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          state_nx_s = ST_ACC;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (last_rule_s) begin
          if (d_next_s == {W_DEN{1'b0}}) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s  = ST_DIV;
            div_start_s = 1'b1;
          end
        end else begin
          state_nx_s = ST_ACC;
        end
      end
      ST_DIV: begin
        if (div_done_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_DIV;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, capture, accumulation and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= ST_IDLE;
      up_r      <= 72'd0;
      low_r     <= 72'd0;
      n_r       <= {W_NUM{1'b0}};
      d_r       <= {W_DEN{1'b0}};
      idx_r     <= 4'd0;
      saida_r   <= 8'd0;
      ocupado_r <= 1'b0;
      pronto_r  <= 1'b0;
      erro_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      ocupado_r <= (state_nx_s != ST_IDLE);
      pronto_r  <= (state_nx_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            up_r  <= Firing_UP;
            low_r <= Firing_LOW;
            n_r   <= {W_NUM{1'b0}};
            d_r   <= {W_DEN{1'b0}};
            idx_r <= 4'd0;
          end
        end
        ST_ACC: begin
          n_r   <= n_next_s;
          d_r   <= d_next_s;
          idx_r <= idx_r + 4'd1;
          if (last_rule_s && (d_next_s == {W_DEN{1'b0}})) begin
            saida_r <= Y_ZERO;
            erro_r  <= 1'b1;
          end
        end
        ST_DIV: begin
          if (div_done_s) begin
            saida_r <= div_quo_s;
            erro_r  <= 1'b0;
          end
        end
        ST_DONE: idx_r <= 4'd0;
        default: idx_r <= 4'd0;
      endcase
    end
  end

  div_restaurador u_div (
    .clk      (CLK),
    .reset    (RESET),
    .start    (div_start_s),
    .dividend (n_next_s),
    .divisor  (d_next_s),
    .done     (div_done_s),
    .quotient (div_quo_s)
  );

endmodule

// File: tb/tb_defuzz_nt.sv
// ---------------------------------------------------------------------------
// tb_defuzz_nt
// Directed vectors with hand-computed results; each launched run pushes its
// expected Saida, Erro and Pronto cycle into a scoreboard queue, and a monitor
// pops and compares on every Pronto pulse.
// ---------------------------------------------------------------------------
module tb_defuzz_nt;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Start;
  logic [71:0] Firing_UP;
  logic [71:0] Firing_LOW;
  logic [7:0]  Saida;
  logic        Ocupado;
  logic        Pronto;
  logic        Erro;

  defuzz_nt dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .Start      (Start),
    .Firing_UP  (Firing_UP),
    .Firing_LOW (Firing_LOW),
    .Saida      (Saida),
    .Ocupado    (Ocupado),
    .Pronto     (Pronto),
    .Erro       (Erro)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] saida;
    logic       erro;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Pronto must match the oldest expectation
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (Pronto) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pronto actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check("saida", Saida, e.saida);
        check("erro", Erro, e.erro);
        check("pronto_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic clear_fire();
    Firing_UP  = 72'd0;
    Firing_LOW = 72'd0;
  endtask

  task automatic set_rule(input int i, input logic [7:0] up, input logic [7:0] lo);
    Firing_UP[i*8 +: 8]  = up;
    Firing_LOW[i*8 +: 8] = lo;
  endtask

  task automatic expect_run(input logic [7:0] s, input logic e, input int lat);
    exp_t x;
    x.saida = s;
    x.erro  = e;
    x.cyc   = cyc + lat;
    sb_q.push_back(x);
  endtask

  // Called at a negedge; Start is sampled at the following posedge
  task automatic pulse_start();
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic launch(input logic [7:0] s, input logic e, input int lat);
    expect_run(s, e, lat);
    pulse_start();
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge CLK);
    end
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout actual=%0d pending expected=0", sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic vec_rule4();
    clear_fire();
    set_rule(4, 8'd100, 8'd60);      // s=160, Y=128 -> 128
  endtask

  task automatic vec_mixed();
    clear_fire();
    set_rule(2, 8'd50, 8'd10);       // s=60,  60*64   = 3840
    set_rule(6, 8'd20, 8'd20);       // s=40,  40*191  = 7640 -> 11480/100 = 114
  endtask

  task automatic vec_uplow();
    clear_fire();
    set_rule(1, 8'd10, 8'd200);      // s=210, 210*32  = 6720
    set_rule(7, 8'd255, 8'd255);     // s=510, 510*223 = 113730 -> 120450/720 = 167
  endtask

  initial begin
    RESET = 1'b1;
    Start = 1'b0;
    clear_fire();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    check("reset_saida", Saida, 0);
    check("reset_pronto", Pronto, 0);
    check("reset_ocupado", Ocupado, 0);
    check("reset_erro", Erro, 0);
    @(negedge CLK);

    // All firings zero: D=0 path
    clear_fire();
    launch(8'd0, 1'b0 | 1'b1, 10);
    drain();

    // Single rule 4
    vec_rule4();
    launch(8'd128, 1'b0, 18);
    drain();

    // Rules 0 and 8: N=51000, D=400 -> 127
    clear_fire();
    set_rule(0, 8'd100, 8'd100);
    set_rule(8, 8'd100, 8'd100);
    launch(8'd127, 1'b0, 18);
    drain();

    vec_mixed();
    launch(8'd114, 1'b0, 18);
    drain();

    // Everything at 255: D=4590, N=510*1148 -> 127
    Firing_UP  = {72{1'b1}};
    Firing_LOW = {72{1'b1}};
    launch(8'd127, 1'b0, 18);
    drain();

    // Extra Start pulses at cycles 3 and 12 are ignored
    vec_rule4();
    launch(8'd128, 1'b0, 18);
    repeat (2) @(negedge CLK);
    check("ocupado_busy", Ocupado, 1);
    pulse_start();
    repeat (8) @(negedge CLK);
    pulse_start();
    drain();
    check("ocupado_idle", Ocupado, 0);
    vec_mixed();
    launch(8'd114, 1'b0, 18);
    drain();

    // Start held high: second run begins right after DONE
    vec_uplow();
    expect_run(8'd167, 1'b0, 18);
    expect_run(8'd167, 1'b0, 37);
    Start = 1'b1;
    repeat (20) @(negedge CLK);
    Start = 1'b0;
    drain();

    // RESET during DIV aborts the run with no Pronto
    vec_rule4();
    pulse_start();
    repeat (12) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("abort_saida", Saida, 0);
    check("abort_pronto", Pronto, 0);
    check("abort_ocupado", Ocupado, 0);
    check("abort_erro", Erro, 0);
    repeat (20) @(negedge CLK);
    launch(8'd128, 1'b0, 18);
    drain();

    // Bus changes after Start must not matter
    vec_rule4();
    launch(8'd128, 1'b0, 18);
    @(negedge CLK);
    Firing_UP  = {72{1'b1}};
    Firing_LOW = {72{1'b1}};
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
